// File: rtl/wb_slave_ram_pkg.sv
// ---------------------------------------------------------------------------
// wb_slave_pkg
//   Shared definitions for the wb_slave_ram Wishbone B4 classic slave memory:
//   bus widths, the controller state encoding and the byte-lane mask helper.
//   Imported by the interface, the storage array and the top level.
// ---------------------------------------------------------------------------
package wb_slave_pkg;

   localparam int WB_DW   = 64;
   localparam int WB_AW   = 64;
   localparam int WB_SELW = 8;
   localparam int WB_TGW  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } wb_slv_state_e;

   // Expands SEL so that bit n covers data bits [8n+7:8n].
   function automatic logic [WB_DW-1:0] sel_to_mask(input logic [WB_SELW-1:0] sel);
      logic [WB_DW-1:0] mask;
      mask = '0;
      for (int i = 0; i < WB_SELW; i++) begin
         mask[8*i +: 8] = {8{sel[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/wb_slave_ram_if.sv
// ---------------------------------------------------------------------------
// wb_slave_ram_if
//   Wishbone B4 classic bus bundle between one master and wb_slave_ram.
//   Master drives CYC/STB/WE/ADR/DAT/SEL/TGA/TGC/TGD/LOCK (the *_I names are
//   as seen from the slave); slave drives DAT_O/TGD_O/ACK_O/ERR_O/RTY_O.
//   Modports: master, slave.
// ---------------------------------------------------------------------------
interface wb_slave_ram_if;
   import wb_slave_pkg::*;

   logic                CYC_I;
   logic                STB_I;
   logic                WE_I;
   logic [WB_AW-1:0]    ADR_I;
   logic [WB_DW-1:0]    DAT_I;
   logic [WB_SELW-1:0]  SEL_I;
   logic [WB_TGW-1:0]   TGA_I;
   logic [WB_TGW-1:0]   TGC_I;
   logic [WB_TGW-1:0]   TGD_I;
   logic                LOCK_I;
   logic [WB_DW-1:0]    DAT_O;
   logic [WB_TGW-1:0]   TGD_O;
   logic                ACK_O;
   logic                ERR_O;
   logic                RTY_O;

   modport master (
      output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, TGA_I, TGC_I, TGD_I, LOCK_I,
      input  DAT_O, TGD_O, ACK_O, ERR_O, RTY_O
   );

   modport slave (
      input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, TGA_I, TGC_I, TGD_I, LOCK_I,
      output DAT_O, TGD_O, ACK_O, ERR_O, RTY_O
   );

endinterface

// File: rtl/wb_slave_ram_array.sv
// ---------------------------------------------------------------------------
// wb_slave_ram_array
//   Single-port DEPTH x 64 storage with per-byte write enables and a
//   registered (synchronous) read port. One access per cycle: en=1,we=1 is a
//   byte-masked write, en=1,we=0 loads the read register.
//   Optional macro WB_SLAVE_RAM_TAG_STORE_EN adds a DEPTH x 16 tag array that
//   is written alongside data whenever at least one byte lane is enabled.
// Ports:
//   clk    in   clock, rising edge
//   en     in   access enable
//   we     in   1 = write, 0 = read
//   idx    in   word index
//   wdata  in   write data
//   be     in   byte-lane write enables
//   wtag   in   write tag (tag array only)
//   rdata  out  registered read data
//   rtag   out  registered read tag (0 without the tag array)
// ---------------------------------------------------------------------------
module wb_slave_ram_array
   import wb_slave_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   localparam int         IDXW  = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                en,
   input  logic                we,
   input  logic [IDXW-1:0]     idx,
   input  logic [WB_DW-1:0]    wdata,
   input  logic [WB_SELW-1:0]  be,
   input  logic [WB_TGW-1:0]   wtag,
   output logic [WB_DW-1:0]    rdata,
   output logic [WB_TGW-1:0]   rtag
);

   logic [WB_DW-1:0] mem [DEPTH];
   logic [WB_DW-1:0] rdata_q;
   logic [WB_DW-1:0] rdata_d;

   // The read register only changes on a read so the word stays available
   // through any wait states that follow the request.
   always_comb begin
      rdata_d = rdata_q;
      if (en && !we) begin
         rdata_d = mem[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int i = 0; i < WB_SELW; i++) begin
            if (be[i]) begin
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

`ifdef WB_SLAVE_RAM_TAG_STORE_EN
   logic [WB_TGW-1:0] tag_mem [DEPTH];
   logic [WB_TGW-1:0] rtag_q;
   logic [WB_TGW-1:0] rtag_d;

   always_comb begin
      rtag_d = rtag_q;
      if (en && !we) begin
         rtag_d = tag_mem[idx];
      end
   end

   // A write with no lanes selected leaves the stored tag untouched too.
   always_ff @(posedge clk) begin
      if (en && we && (|be)) begin
         tag_mem[idx] <= wtag;
      end
      rtag_q <= rtag_d;
   end

   assign rtag = rtag_q;
`else
   logic unused_wtag;
   assign unused_wtag = ^wtag;
   assign rtag        = '0;
`endif

endmodule

// File: rtl/wb_slave_ram.sv
// ---------------------------------------------------------------------------
// wb_slave_ram
//   Wishbone B4 classic-cycle slave memory, 64-bit data with byte selects and
//   WAIT_STATES idle cycles between request sample and termination.
//   Out-of-range or misaligned addresses terminate with ERR. RTY is never used.
//   Optional macro WB_SLAVE_RAM_TAG_STORE_EN stores TGD_I per word and returns
//   it on TGD_O for reads; without it TGD_O is constant 0.
// Parameters:
//   DEPTH        number of 64-bit words, power of two, >= 2
//   BASE_ADDR    byte address of word 0, 8-byte aligned
//   WAIT_STATES  0..15
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous reset, active low
//   bus   wb_slave_ram_if.slave  Wishbone bus (inputs *_I, outputs *_O)
// ---------------------------------------------------------------------------
module wb_slave_ram
   import wb_slave_pkg::*;
#(
   parameter int unsigned      DEPTH       = 1024,
   parameter logic [WB_AW-1:0] BASE_ADDR   = 64'h0,
   parameter int unsigned      WAIT_STATES = 0
) (
   input  logic           clk,
   input  logic           rst,
   wb_slave_ram_if.slave  bus
);

   localparam int IDXW = $clog2(DEPTH);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_WAIT = WAIT;
   localparam logic [1:0] ST_RESP = RESP;

   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   logic [1:0]          state_q,  state_d;
   logic [3:0]          cnt_q,    cnt_d;
   logic                we_q,     we_d;
   logic [WB_DW-1:0]    dat_q,    dat_d;
   logic [WB_SELW-1:0]  sel_q,    sel_d;
   logic [WB_TGW-1:0]   tgd_q,    tgd_d;
   logic                bad_q,    bad_d;
   logic [IDXW-1:0]     idx_q,    idx_d;
   logic                ack_q,    ack_d;
   logic                err_q,    err_d;
   logic [WB_DW-1:0]    dat_o_q,  dat_o_d;
   logic [WB_TGW-1:0]   tgd_o_q,  tgd_o_d;

   logic [WB_AW-1:0]    req_off;
   logic                req_bad;
   logic [IDXW-1:0]     req_idx;

   logic                mem_en;
   logic                mem_we;
   logic [IDXW-1:0]     mem_idx;
   logic [WB_DW-1:0]    mem_rdata;
   logic [WB_TGW-1:0]   mem_rtag;

   // Range check on the offset rather than on BASE_ADDR + DEPTH*8 so that a
   // base near the top of the address space cannot overflow. BASE_ADDR is
   // aligned, so offset[2:0] equals ADR_I[2:0].
   always_comb begin
      req_off = bus.ADR_I - BASE_ADDR;
      req_bad = (bus.ADR_I < BASE_ADDR)
             || (req_off[WB_AW-1:IDXW+3] != '0)
             || (req_off[2:0] != 3'd0);
      req_idx = req_off[IDXW+2:3];
   end

   // Controller. The array read is issued on the sampling edge so the word is
   // ready by RESP regardless of wait states; a write commits on the edge
   // that raises ACK. Outputs default to 0 so every termination is one cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      tgd_d   = tgd_q;
      bad_d   = bad_q;
      idx_d   = idx_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      dat_o_d = '0;
      tgd_o_d = '0;
      mem_en  = 1'b0;
      mem_we  = 1'b0;
      mem_idx = req_idx;

      case (state_q)
         ST_IDLE: begin
            if (bus.CYC_I && bus.STB_I) begin
               we_d   = bus.WE_I;
               dat_d  = bus.DAT_I;
               sel_d  = bus.SEL_I;
               tgd_d  = bus.TGD_I;
               bad_d  = req_bad;
               idx_d  = req_idx;
               mem_en = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WS_LOAD;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end

         ST_WAIT: begin
            if (!(bus.CYC_I && bus.STB_I)) begin
               state_d = ST_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
            if (bad_q) begin
               err_d = 1'b1;
            end else begin
               ack_d = 1'b1;
               if (we_q) begin
                  mem_en  = 1'b1;
                  mem_we  = 1'b1;
                  mem_idx = idx_q;
               end else begin
                  dat_o_d = mem_rdata & sel_to_mask(sel_q);
                  tgd_o_d = mem_rtag;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // All controller state and every bus output; reset drops any pending
   // write because the write strobe is only generated from RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         dat_q   <= '0;
         sel_q   <= '0;
         tgd_q   <= '0;
         bad_q   <= 1'b0;
         idx_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_o_q <= '0;
         tgd_o_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         tgd_q   <= tgd_d;
         bad_q   <= bad_d;
         idx_q   <= idx_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_o_q <= dat_o_d;
         tgd_o_q <= tgd_o_d;
      end
   end

   wb_slave_ram_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk   (clk),
      .en    (mem_en),
      .we    (mem_we),
      .idx   (mem_idx),
      .wdata (dat_q),
      .be    (sel_q),
      .wtag  (tgd_q),
      .rdata (mem_rdata),
      .rtag  (mem_rtag)
   );

   assign bus.ACK_O = ack_q;
   assign bus.ERR_O = err_q;
   assign bus.RTY_O = 1'b0;
   assign bus.DAT_O = dat_o_q;
   assign bus.TGD_O = tgd_o_q;

   // Address/cycle tags and LOCK carry no meaning for a single-master RAM.
   logic unused_inputs;
   assign unused_inputs = ^{bus.TGA_I, bus.TGC_I, bus.LOCK_I};

endmodule

// File: tb/tb_wb_slave_ram.sv
// ---------------------------------------------------------------------------
// tb_wb_slave_ram
//   Three wb_slave_ram instances (WAIT_STATES 0, 3, 2; DEPTH 1024, base 0)
//   driven by directed transactions. Each transaction pushes its expected
//   termination into a per-instance queue; a monitor pops and compares
//   whenever an instance shows ACK or ERR. Tag expectations follow
//   WB_SLAVE_RAM_TAG_STORE_EN.
// ---------------------------------------------------------------------------
module tb_wb_slave_ram;
   import wb_slave_pkg::*;

   typedef struct packed {
      logic        is_err;
      logic        chk_dat;
      logic [63:0] dat;
      logic [15:0] tgd;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  cyc, stb, we, ack, err, rty;
   logic [63:0] adr   [3];
   logic [63:0] dat   [3];
   logic [63:0] dat_o [3];
   logic [7:0]  sel   [3];
   logic [15:0] tgd   [3];
   logic [15:0] tgd_o [3];

   int checks   = 0;
   int errors   = 0;
   bit in_reset = 1'b1;

   exp_t exp_q0[$];
   exp_t exp_q1[$];
   exp_t exp_q2[$];

   function automatic int wsOf(input int i);
      case (i)
         0:       return 0;
         1:       return 3;
         default: return 2;
      endcase
   endfunction

   function automatic logic [15:0] tagExp(input logic [15:0] t);
`ifdef WB_SLAVE_RAM_TAG_STORE_EN
      return t;
`else
      return 16'h0 & t;
`endif
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      wb_slave_ram_if bus ();

      assign bus.CYC_I  = cyc[g];
      assign bus.STB_I  = stb[g];
      assign bus.WE_I   = we[g];
      assign bus.ADR_I  = adr[g];
      assign bus.DAT_I  = dat[g];
      assign bus.SEL_I  = sel[g];
      assign bus.TGA_I  = 16'h0;
      assign bus.TGC_I  = 16'h0;
      assign bus.TGD_I  = tgd[g];
      assign bus.LOCK_I = 1'b0;
      assign ack[g]     = bus.ACK_O;
      assign err[g]     = bus.ERR_O;
      assign rty[g]     = bus.RTY_O;
      assign dat_o[g]   = bus.DAT_O;
      assign tgd_o[g]   = bus.TGD_O;

      wb_slave_ram #(
         .DEPTH       (1024),
         .BASE_ADDR   (64'h0),
         .WAIT_STATES (wsOf(g))
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   task automatic compare(input string name, input int i, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s inst%0d got=%h expected=%h", name, i, act, expv);
      end
   endtask

   task automatic pushExp(input int i, input exp_t e);
      case (i)
         0:       exp_q0.push_back(e);
         1:       exp_q1.push_back(e);
         default: exp_q2.push_back(e);
      endcase
   endtask

   // Monitor side: called whenever an instance terminates a cycle.
   task automatic checkOutput(input int i);
      exp_t e;
      bit   have;
      have = 1'b0;
      e    = '0;
      case (i)
         0: if (exp_q0.size() != 0) begin e = exp_q0.pop_front(); have = 1'b1; end
         1: if (exp_q1.size() != 0) begin e = exp_q1.pop_front(); have = 1'b1; end
         default: if (exp_q2.size() != 0) begin e = exp_q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
         checks++;
         errors++;
         $display("[TB] FAIL unexpected_term inst%0d got ack=%0b err=%0b expected none", i, ack[i], err[i]);
      end else begin
         compare("term_kind", i, 64'({ack[i], err[i]}), 64'({!e.is_err, e.is_err}));
         compare("rty", i, 64'(rty[i]), 64'd0);
         if (e.chk_dat) begin
            compare("dat_o", i, dat_o[i], e.dat);
            compare("tgd_o", i, 64'(tgd_o[i]), 64'(e.tgd));
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!in_reset) begin
            for (int i = 0; i < 3; i++) begin
               if (ack[i] || err[i]) checkOutput(i);
            end
         end
      end
   end

   // Stimulus side: one full classic cycle, started and finished on a
   // falling edge; also checks latency, output quiet time and the single
   // termination cycle.
   task automatic applyStimulus(input int i, input bit wr, input logic [63:0] a, input logic [63:0] d,
                                input logic [7:0] s, input logic [15:0] t, input bit exp_err,
                                input logic [63:0] exp_dat, input logic [15:0] exp_tgd);
      exp_t e;
      int   k;
      bit   done;
      bit   quiet;
      e.is_err  = exp_err;
      e.chk_dat = !wr || exp_err;
      e.dat     = exp_dat;
      e.tgd     = exp_tgd;
      pushExp(i, e);
      cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = wr;
      adr[i] = a; dat[i] = d; sel[i] = s; tgd[i] = t;
      k = 0; done = 1'b0; quiet = 1'b1;
      while (!done && k < 40) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (ack[i] || err[i]) done = 1'b1;
         else if (dat_o[i] != 64'd0 || tgd_o[i] != 16'd0) quiet = 1'b0;
      end
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL timeout inst%0d addr=%h got no termination expected one", i, a);
      end else begin
         compare("latency", i, 64'(k - 1), 64'(wsOf(i) + 1));
         compare("quiet_before_term", i, 64'(quiet), 64'd1);
         @(negedge clk);
         compare("single_cycle_term", i, 64'({ack[i], err[i]}), 64'd0);
         compare("dat_o_after", i, dat_o[i], 64'd0);
      end
   endtask

   task automatic doWrite(input int i, input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] s, input logic [15:0] t, input bit bad);
      applyStimulus(i, 1'b1, a, d, s, t, bad, 64'd0, 16'd0);
   endtask

   task automatic doRead(input int i, input logic [63:0] a, input logic [7:0] s, input bit bad,
                         input logic [63:0] exp_dat, input logic [15:0] exp_tgd);
      applyStimulus(i, 1'b0, a, 64'd0, s, 16'd0, bad, exp_dat, exp_tgd);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog got no completion expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      bit quiet;
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
         adr[i] = 64'd0; dat[i] = 64'd0; sel[i] = 8'd0; tgd[i] = 16'd0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         compare("reset_ack", i, 64'(ack[i]), 64'd0);
         compare("reset_err", i, 64'(err[i]), 64'd0);
         compare("reset_rty", i, 64'(rty[i]), 64'd0);
         compare("reset_dat_o", i, dat_o[i], 64'd0);
         compare("reset_tgd_o", i, 64'(tgd_o[i]), 64'd0);
      end
      rst = 1'b1;
      in_reset = 1'b0;
      @(negedge clk);

      $display("[TB] basic write/read, zero wait states");
      doWrite(0, 64'h10, 64'h1122334455667788, 8'hFF, 16'h1234, 1'b0);
      doRead (0, 64'h10, 8'hFF, 1'b0, 64'h1122334455667788, tagExp(16'h1234));

      $display("[TB] byte lanes");
      doWrite(0, 64'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 16'hA1A1, 1'b0);
      doWrite(0, 64'h18, 64'h0, 8'h0F, 16'hB2B2, 1'b0);
      doRead (0, 64'h18, 8'hFF, 1'b0, 64'hFFFF_FFFF_0000_0000, tagExp(16'hB2B2));
      doRead (0, 64'h18, 8'hF0, 1'b0, 64'hFFFF_FFFF_0000_0000, tagExp(16'hB2B2));
      doRead (0, 64'h18, 8'h3C, 1'b0, 64'h0000_FFFF_0000_0000, tagExp(16'hB2B2));
      doWrite(0, 64'h18, 64'h5555_5555_5555_5555, 8'h00, 16'hC3C3, 1'b0);
      doRead (0, 64'h18, 8'hFF, 1'b0, 64'hFFFF_FFFF_0000_0000, tagExp(16'hB2B2));

      $display("[TB] range check");
      doWrite(0, 64'h0, 64'h0123456789ABCDEF, 8'hFF, 16'h0101, 1'b0);
      doWrite(0, 64'h2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 16'hDEAD, 1'b1);
      doRead (0, 64'h0, 8'hFF, 1'b0, 64'h0123456789ABCDEF, tagExp(16'h0101));
      doRead (0, 64'h2000, 8'hFF, 1'b1, 64'd0, 16'd0);
      doWrite(0, 64'h1FF8, 64'hCAFE_F00D_1234_5678, 8'hFF, 16'h0FF8, 1'b0);
      doRead (0, 64'h1FF8, 8'hFF, 1'b0, 64'hCAFE_F00D_1234_5678, tagExp(16'h0FF8));
      doRead (0, 64'h4, 8'hFF, 1'b1, 64'd0, 16'd0);
      doWrite(0, 64'h4, 64'h1, 8'hFF, 16'h0004, 1'b1);
      doRead (0, 64'h0, 8'hFF, 1'b0, 64'h0123456789ABCDEF, tagExp(16'h0101));

      $display("[TB] tag store");
      doWrite(0, 64'h8, 64'h8888_8888_8888_8888, 8'hFF, 16'hBEEF, 1'b0);
      doRead (0, 64'h8, 8'hFF, 1'b0, 64'h8888_8888_8888_8888, tagExp(16'hBEEF));

      $display("[TB] three wait states");
      doWrite(1, 64'h0, 64'h3333_4444_5555_6666, 8'hFF, 16'h3131, 1'b0);
      doRead (1, 64'h0, 8'hFF, 1'b0, 64'h3333_4444_5555_6666, tagExp(16'h3131));
      doRead (1, 64'h4, 8'hFF, 1'b1, 64'd0, 16'd0);

      $display("[TB] abort by dropping CYC");
      doWrite(2, 64'h20, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 16'h2020, 1'b0);
      cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
      adr[2] = 64'h20; dat[2] = 64'h5555_5555_5555_5555; sel[2] = 8'hFF; tgd[2] = 16'h5A5A;
      @(posedge clk);
      @(negedge clk);
      cyc[2] = 1'b0;
      quiet = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (ack[2] || err[2]) quiet = 1'b0;
      end
      compare("abort_no_term", 2, 64'(quiet), 64'd1);
      stb[2] = 1'b0; we[2] = 1'b0;
      doRead (2, 64'h20, 8'hFF, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, tagExp(16'h2020));

      $display("[TB] reset mid-transfer");
      cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
      adr[2] = 64'h20; dat[2] = 64'h7777_7777_7777_7777; sel[2] = 8'hFF; tgd[2] = 16'h7A7A;
      e.is_err = 1'b0; e.chk_dat = 1'b1;
      e.dat = 64'h1122334455667788; e.tgd = tagExp(16'h1234);
      pushExp(0, e);
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 64'h10; sel[0] = 8'hFF;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      compare("pre_reset_ack", 0, 64'(ack[0]), 64'd1);
      cyc[0] = 1'b0; stb[0] = 1'b0;
      #2;
      in_reset = 1'b1;
      rst = 1'b0;
      #1;
      compare("reset_clears_ack", 0, 64'(ack[0]), 64'd0);
      compare("reset_clears_dat_o", 0, dat_o[0], 64'd0);
      compare("reset_wait_term", 2, 64'({ack[2], err[2]}), 64'd0);
      cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      in_reset = 1'b0;
      @(negedge clk);
      doRead (2, 64'h20, 8'hFF, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, tagExp(16'h2020));

      repeat (3) @(negedge clk);
      compare("queue_empty", 0, 64'(exp_q0.size()), 64'd0);
      compare("queue_empty", 1, 64'(exp_q1.size()), 64'd0);
      compare("queue_empty", 2, 64'(exp_q2.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
